mandala_vga_timing: RTL and testbench

MANDALA_VGA_TIMING -- requirements
Module: mandala_vga_timing

---
 rtl/mandala_vga_timing.sv | 128 ++++++++++++
 tb/tb_mandala_vga_timing.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mandala_vga_timing.sv
// ============================================================================
// Module   : mandala_vga_timing
// Brief    : VGA raster timing generator; all flags registered from next count
// Revision : 1.0
// ============================================================================
`default_nettype none

module mandala_vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 does not alias to 0
    localparam logic [10:0] c_H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] c_HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] c_VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (c_H_TOTAL > 1024 || c_V_TOTAL > 1024) begin : g_size_check
            $error("mandala_vga_timing: H_TOTAL and V_TOTAL must be <= 1024");
        end
    endgenerate

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic [7:0] fc_q, fc_d;

    logic [9:0] h_nxt_w;
    logic [9:0] v_nxt_w;
    logic       h_wrap_w;

    assign h_wrap_w = (hpos_q == c_H_LAST);
    assign h_nxt_w  = h_wrap_w ? 10'd0 : hpos_q + 10'd1;
    assign v_nxt_w  = !h_wrap_w ? vpos_q :
                      (vpos_q == c_V_LAST) ? 10'd0 : vpos_q + 10'd1;

    // Flags are decoded from the upcoming position so they land with it
    always_comb begin
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        fc_d    = fc_q;
        if (ena) begin
            hpos_d  = h_nxt_w;
            vpos_d  = v_nxt_w;
            hsync_d = ({1'b0, h_nxt_w} >= c_HS_START && {1'b0, h_nxt_w} < c_HS_END)
                      ? SYNC_POL : ~SYNC_POL;
            vsync_d = ({1'b0, v_nxt_w} >= c_VS_START && {1'b0, v_nxt_w} < c_VS_END)
                      ? SYNC_POL : ~SYNC_POL;
            de_d    = ({1'b0, h_nxt_w} < c_H_VIS) && ({1'b0, v_nxt_w} < c_V_VIS);
            ls_d    = (h_nxt_w == 10'd0);
            fs_d    = (h_nxt_w == 10'd0) && (v_nxt_w == 10'd0);
            if ((h_nxt_w == 10'd0) && (v_nxt_w == 10'd0)) begin
                fc_d = fc_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q  <= c_H_LAST;
            vpos_q  <= c_V_LAST;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= 8'hFF;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;

endmodule

`default_nettype wire

// File: tb/tb_mandala_vga_timing.sv
// ============================================================================
// Module   : tb_mandala_vga_timing
// Brief    : Directed bench; default 640x480 timing plus a tiny active-high raster
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mandala_vga_timing;

    logic       clk = 1'b0;
    logic       rst_n0, rst_n1;
    logic       ena0, ena1;

    logic [9:0] hpos0, vpos0, hpos1, vpos1;
    logic       hs0, vs0, de0, ls0, fs0;
    logic       hs1, vs1, de1, ls1, fs1;
    logic [7:0] fc0, fc1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mandala_vga_timing u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n0),
        .ena         (ena0),
        .hpos        (hpos0),
        .vpos        (vpos0),
        .hsync       (hs0),
        .vsync       (vs0),
        .display_on  (de0),
        .line_start  (ls0),
        .frame_start (fs0),
        .frame_count (fc0)
    );

    // Small raster: H_TOTAL=15 (sync 10..12), V_TOTAL=10 (sync lines 7..8), 150 cycles/frame
    mandala_vga_timing #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b1)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n1),
        .ena         (ena1),
        .hpos        (hpos1),
        .vpos        (vpos1),
        .hsync       (hs1),
        .vsync       (vs1),
        .display_on  (de1),
        .line_start  (ls1),
        .frame_start (fs1),
        .frame_count (fc1)
    );

    typedef struct {
        bit ena;
        int n;
        int h;
        int v;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
        int fc;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step0(input bit en, input int n);
        for (int i = 0; i < n; i++) begin
            ena0 = en;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step1(input bit en, input int n);
        for (int i = 0; i < n; i++) begin
            ena1 = en;
            @(posedge clk);
            #1;
        end
    endtask

    int cnt_hs, cnt_vs, cnt_de, cnt_ls, cnt_fs;

    initial begin
        // {ena, edges, hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count}
        tbl[0]  = '{1'b1,   1,   0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        tbl[1]  = '{1'b1,   1,   1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 638, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1,   1, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1,  16, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[5]  = '{1'b1,  95, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[6]  = '{1'b1,   1, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[7]  = '{1'b1,  47, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[8]  = '{1'b1,   1,   0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[9]  = '{1'b1, 300, 300, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[10] = '{1'b0,  37, 300, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[11] = '{1'b1,   1, 301, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[12] = '{1'b1, 499,   0, 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[13] = '{1'b0,   1,   0, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[14] = '{1'b1,   1,   1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};

        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        ena0   = 1'b0;
        ena1   = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst0_hpos", int'(hpos0), 799);
        check("rst0_vpos", int'(vpos0), 524);
        check("rst0_hsync", int'(hs0), 1);
        check("rst0_vsync", int'(vs0), 1);
        check("rst0_de", int'(de0), 0);
        check("rst0_ls", int'(ls0), 0);
        check("rst0_fs", int'(fs0), 0);
        check("rst0_fc", int'(fc0), 255);
        check("rst1_hsync", int'(hs1), 0);
        check("rst1_vsync", int'(vs1), 0);

        rst_n0 = 1'b1;
        rst_n1 = 1'b1;
        step0(1'b0, 2);
        check("ena_low_hold_hpos", int'(hpos0), 799);

        for (int i = 0; i < 15; i++) begin
            step0(tbl[i].ena, tbl[i].n);
            check($sformatf("vec%0d_hpos", i), int'(hpos0), tbl[i].h);
            check($sformatf("vec%0d_vpos", i), int'(vpos0), tbl[i].v);
            check($sformatf("vec%0d_hsync", i), int'(hs0), int'(tbl[i].hs));
            check($sformatf("vec%0d_vsync", i), int'(vs0), int'(tbl[i].vs));
            check($sformatf("vec%0d_de", i), int'(de0), int'(tbl[i].de));
            check($sformatf("vec%0d_ls", i), int'(ls0), int'(tbl[i].ls));
            check($sformatf("vec%0d_fs", i), int'(fs0), int'(tbl[i].fs));
            check($sformatf("vec%0d_fc", i), int'(fc0), tbl[i].fc);
        end

        // One full line from hpos=1 through hpos=0 of the next line
        cnt_hs = 0; cnt_de = 0; cnt_ls = 0; cnt_fs = 0;
        for (int i = 0; i < 800; i++) begin
            step0(1'b1, 1);
            if (hs0 == 1'b0) cnt_hs++;
            if (de0) cnt_de++;
            if (ls0) cnt_ls++;
            if (fs0) cnt_fs++;
        end
        check("line_hsync_cycles", cnt_hs, 96);
        check("line_de_cycles", cnt_de, 640);
        check("line_ls_count", cnt_ls, 1);
        check("line_fs_count", cnt_fs, 0);
        check("line_end_hpos", int'(hpos0), 1);
        check("line_end_vpos", int'(vpos0), 3);

        // Small raster: reach hpos=11, vpos=7 (both syncs active), then async reset
        step1(1'b1, 117);
        check("s_pre_hpos", int'(hpos1), 11);
        check("s_pre_vpos", int'(vpos1), 7);
        check("s_pre_hsync", int'(hs1), 1);
        check("s_pre_vsync", int'(vs1), 1);
        rst_n1 = 1'b0;
        #1;
        check("s_arst_hpos", int'(hpos1), 14);
        check("s_arst_vpos", int'(vpos1), 9);
        check("s_arst_hsync", int'(hs1), 0);
        check("s_arst_vsync", int'(vs1), 0);
        check("s_arst_fc", int'(fc1), 255);
        check("s_arst_de", int'(de1), 0);
        #2;
        rst_n1 = 1'b1;

        // One full small frame: edges 1..150 after reset
        cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_ls = 0; cnt_fs = 0;
        for (int i = 0; i < 150; i++) begin
            step1(1'b1, 1);
            if (i == 0) begin
                check("s_first_fs", int'(fs1), 1);
                check("s_first_fc", int'(fc1), 0);
                check("s_first_de", int'(de1), 1);
            end
            if (hs1) cnt_hs++;
            if (vs1) cnt_vs++;
            if (de1) cnt_de++;
            if (ls1) cnt_ls++;
            if (fs1) cnt_fs++;
        end
        check("s_frame_hsync", cnt_hs, 30);
        check("s_frame_vsync", cnt_vs, 30);
        check("s_frame_de", cnt_de, 48);
        check("s_frame_ls", cnt_ls, 10);
        check("s_frame_fs", cnt_fs, 1);
        check("s_frame_end_hpos", int'(hpos1), 14);
        check("s_frame_end_vpos", int'(vpos1), 9);

        step1(1'b1, 1);
        check("s_fc_second", int'(fc1), 1);
        check("s_fs_second", int'(fs1), 1);
        check("s_ls_second", int'(ls1), 1);

        // Frame_start at edge 1+150*k carries count k; advance to k=255 then wrap
        cnt_fs = 0;
        for (int i = 0; i < 150 * 254; i++) begin
            step1(1'b1, 1);
            if (fs1) cnt_fs++;
        end
        check("s_fs_over_254", cnt_fs, 254);
        check("s_fc_255", int'(fc1), 255);
        check("s_fc_255_fs", int'(fs1), 1);
        step1(1'b1, 150);
        check("s_fc_wrap", int'(fc1), 0);
        check("s_fc_wrap_fs", int'(fs1), 1);
        check("s_fc_wrap_hpos", int'(hpos1), 0);
        check("s_fc_wrap_vpos", int'(vpos1), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
